twiddle_request_sequencer: RTL and testbench
============================================

Name: twiddle_request_sequencer

Overview:
- Sequences one radix-2 DIT FFT/IFFT pass over N = 2^FFT_N points.
- Per butterfly issue, produces the top/bottom data addresses and the twiddle request for the twiddle ROM bridge: tact_rom, ta_rom, evenOdd, ifft.
- Orders butterflies so a twiddle is fetched once and reused, and enforces the bridge's two-cycle ROM occupancy.
- Sits between the FFT top-level control and the butterfly datapath/bridge.

Parameters:
- FFT_N, 10, log2 of transform length.
- STAGE_GAP, 4, idle cycles inserted between stages for butterfly write-back, minimum 1.
- DRAIN_LAT, 3, cycles after the last issue before done, matching bridge latency.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a transform; sampled only in IDLE.
- ifft_in  in  1  direction, latched at start.
- out_ready  in  1  butterfly datapath can accept an issue this cycle.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of transform.
- stage  out  $clog2(FFT_N)  current stage index.
- bf_top  out  FFT_N  top operand address.
- bf_bot  out  FFT_N  bottom operand address (bf_top + 2^stage).
- tact_rom  out  1  issue strobe / twiddle request valid.
- ta_rom  out  FFT_N-1  twiddle index.
- evenOdd  out  1  0 = fetch new twiddle from ROM; 1 = reuse previously fetched twiddle.
- ifft  out  1  latched direction.

Behaviour:
- Reset (rst_n low at a clock edge, any state, including mid-transform):
  - state = IDLE.
  - All counters = 0.
  - busy = done = tact_rom = evenOdd = ifft = 0; stage, bf_top, bf_bot, ta_rom = 0.
  - A pending transform is abandoned with no done pulse.
- Loop order:
  - Stage s = 0..FFT_N-1.
  - Twiddle slot j = 0..2^s-1 (outer).
  - Group g = 0..2^(FFT_N-1-s)-1 (inner).
- Per issue:
  - bf_top = g*2^(s+1) + j.
  - bf_bot = bf_top + 2^s.
  - ta_rom = (j << (FFT_N-1-s)) truncated to FFT_N-1 bits.
  - evenOdd = (g != 0).
- All outputs are registered; they are valid in the same cycle as tact_rom.
- Issue rule: tact_rom is high for exactly one cycle per butterfly, only when out_ready = 1 and the state is RUN.
- Issue gating:
  - If out_ready = 0, no issue occurs and the counters hold.
  - Address outputs hold their last values.
- ROM-occupancy rule: an issue with evenOdd = 0 must not occur in the cycle immediately after an issue with evenOdd = 0. The FSM inserts one BUBBLE cycle (tact_rom = 0) in that case.
- States:
  - IDLE: start → RUN; latch ifft_in; busy = 1 next cycle. start while busy is ignored.
  - RUN: issue per rules.
    - On the last (j, g) of a stage that is not the last stage → GAP.
    - On the last (j, g) of the last stage → DRAIN.
    - If the next issue needs a bubble → BUBBLE.
  - BUBBLE: one cycle, no issue → RUN.
  - GAP: STAGE_GAP cycles, no issue; stage increments on entry → RUN.
  - DRAIN: DRAIN_LAT cycles → DONE.
  - DONE: done = 1 for one cycle, busy = 0 next cycle → IDLE.
- A start in the same cycle as done is ignored; start is accepted from IDLE only.
- Issue count per transform: FFT_N * 2^(FFT_N-1).
- Bubbles: the last stage needs 2^(FFT_N-1)-1 bubbles; no other stage needs any when FFT_N ≥ 2.
- Boundaries:
  - The stage counter never wraps past FFT_N-1.
  - ta_rom for stage 0 is always 0.
  - out_ready deasserted during BUBBLE/GAP has no effect.

Optional Feature:
- Macro: TWIDDLE_SEQ_STATS_EN.
- When defined:
  - Adds output rom_fetches (FFT_N+1 bits): count of evenOdd = 0 issues.
  - Adds output stall_cycles (16 bits, saturating): cycles in RUN with out_ready = 0.
  - Both clear at start; both clear on reset.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package fft_pkg holds:
  - FSM state enum: IDLE, RUN, BUBBLE, GAP, DRAIN, DONE.
  - Function computing the twiddle index from (j, s, FFT_N).
  - Function computing the stage width $clog2(FFT_N).
- One natural sub-module: fft_index_counter, the nested j/g/stage counter with last-of-stage/last-of-transform flags. The FSM and output registers stay in the top.

Test Plan:
- FFT_N=4, out_ready=1, start pulse:
  - Stage 0: 8 issues, ta_rom = 0, evenOdd = 0,1,1,1,1,1,1,1; bf_top = 0,2,4,…,14.
  - done asserts after the full sequence.
- FFT_N=4, stage 3:
  - ta_rom = 0..7, each evenOdd = 0, bf_top = 0..7, bf_bot = 8..15.
  - Exactly one bubble cycle between consecutive issues (7 bubbles).
- FFT_N=4, stage 1:
  - (bf_top, bf_bot, ta_rom) = (0,2,0),(4,6,0),(8,10,0),(12,14,0),(1,3,4),(5,7,4),(9,11,4),(13,15,4).
  - evenOdd = 0 only on the first issue of each j.
- Random out_ready (50%):
  - Issue sequence is identical to the out_ready=1 run.
  - No two adjacent-cycle evenOdd = 0 issues.
  - Total issues = 32.
- rst_n low for one cycle during stage 2, then start:
  - All outputs are 0 in the cycle after reset.
  - No done pulse from the aborted run.
  - The new run restarts at stage 0, bf_top = 0.
- ifft_in = 1 at start, ifft_in toggled mid-run: ifft = 1 for the whole run. Second start while busy is ignored, so done pulses exactly once.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the twiddle request sequencer.
//   seq_state_e   : sequencer FSM states
//   stage_width   : width of the stage index for a transform of 2^n points
//   twiddle_index : twiddle ROM index for slot j in stage s of a 2^n-point pass
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    BUBBLE,
    GAP,
    DRAIN,
    DONE
  } seq_state_e;

  // Never narrower than one bit, so small transforms still get a legal vector.
  function automatic int stage_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Stage s uses every 2^(n-1-s)-th twiddle; the index is kept to n-1 bits.
  function automatic int unsigned twiddle_index(input int unsigned j,
                                                input int unsigned s,
                                                input int unsigned n);
    int unsigned mask;
    mask = (32'd1 << (n - 1)) - 32'd1;
    return (j << (n - 1 - s)) & mask;
  endfunction

endpackage

// File: rtl/fft_index_counter.sv
// Nested butterfly index counter for one radix-2 DIT pass.
// Loop order: stage (outermost), twiddle slot j, group g (innermost), so that
// one fetched twiddle is reused across all groups of a slot.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   clear               : return all counters to zero (new transform)
//   advance             : one butterfly was issued with the current indices
//   j, g, stage         : current slot, group and stage
//   g_last              : g is the last group of the current slot
//   last_of_stage       : current (j, g) is the final butterfly of the stage
//   last_of_transform   : final butterfly of the final stage
module fft_index_counter
  import fft_pkg::*;
#(
  parameter int FFT_N = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           advance,
  output logic [FFT_N-2:0]               j,
  output logic [FFT_N-2:0]               g,
  output logic [stage_width(FFT_N)-1:0]  stage,
  output logic                           g_last,
  output logic                           last_of_stage,
  output logic                           last_of_transform
);

  localparam int IW = FFT_N - 1;
  localparam int SW = stage_width(FFT_N);

  logic [IW-1:0] j_max;
  logic [IW-1:0] g_max;
  logic          last_stage;

  // 2^s - 1 and 2^(FFT_N-1-s) - 1; the shift overflowing to zero at the
  // extreme stage wraps to all-ones, which is exactly the wanted maximum.
  assign j_max             = (IW'(1) << stage) - IW'(1);
  assign g_max             = (IW'(1) << (SW'(FFT_N - 1) - stage)) - IW'(1);
  assign last_stage        = (stage == SW'(FFT_N - 1));
  assign g_last            = (g == g_max);
  assign last_of_stage     = g_last && (j == j_max);
  assign last_of_transform = last_of_stage && last_stage;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      j     <= '0;
      g     <= '0;
      stage <= '0;
    end else if (advance) begin
      if (g_last) begin
        g <= '0;
        if (j == j_max) begin
          j <= '0;
          // Stage saturates at the last stage; it is only cleared by a new start.
          if (!last_stage) stage <= stage + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end else begin
        g <= g + 1'b1;
      end
    end
  end

endmodule

// File: rtl/twiddle_request_sequencer.sv
// Sequences one radix-2 DIT FFT/IFFT pass over 2^FFT_N points and issues
// butterfly addresses plus twiddle ROM requests to the bridge.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start, ifft_in  : begin a transform (IDLE only), direction latched at start
//   out_ready       : datapath can take an issue
//   busy, done      : transform in progress / one-cycle completion pulse
//   stage           : stage of the current issue
//   bf_top, bf_bot  : operand addresses of the current issue
//   tact_rom        : issue strobe / twiddle request valid
//   ta_rom          : twiddle index
//   evenOdd         : 0 = fetch new twiddle, 1 = reuse previous twiddle
//   ifft            : latched direction
//   dbg_state       : current FSM state
//   rom_fetches, stall_cycles : statistics, present only with TWIDDLE_SEQ_STATS_EN
// Optional macro: TWIDDLE_SEQ_STATS_EN.
//
// Handshake: out_ready is sampled in RUN at a rising edge; when it is high
// the butterfly is accepted at that edge and tact_rom plus every address
// output are high/valid for exactly the following cycle. There is no
// back-pressure on a presented issue; out_ready low simply withholds one.
module twiddle_request_sequencer
  import fft_pkg::*;
#(
  parameter int FFT_N     = 10,
  parameter int STAGE_GAP = 4,
  parameter int DRAIN_LAT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          ifft_in,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic [stage_width(FFT_N)-1:0] stage,
  output logic [FFT_N-1:0]              bf_top,
  output logic [FFT_N-1:0]              bf_bot,
  output logic                          tact_rom,
  output logic [FFT_N-2:0]              ta_rom,
  output logic                          evenOdd,
  output logic                          ifft,
  output seq_state_e                    dbg_state
`ifdef TWIDDLE_SEQ_STATS_EN
  ,
  output logic [FFT_N:0]                rom_fetches,
  output logic [15:0]                   stall_cycles
`endif
);

  localparam int SW       = stage_width(FFT_N);
  localparam int AW       = FFT_N;
  localparam int IW       = FFT_N - 1;
  localparam int WAIT_MAX = (STAGE_GAP > DRAIN_LAT) ? STAGE_GAP : DRAIN_LAT;
  localparam int WW       = $clog2(WAIT_MAX + 1);

  seq_state_e    state;
  seq_state_e    state_next;
  logic [WW-1:0] wait_cnt;

  logic [IW-1:0] cnt_j;
  logic [IW-1:0] cnt_g;
  logic [SW-1:0] cnt_stage;
  logic          g_last;
  logic          stage_last;
  logic          xform_last;

  logic          issue;
  logic          accept_start;
  logic          busy_d;
  logic          done_d;
  logic          need_bubble;
  logic [AW-1:0] top_n;
  logic [AW-1:0] bot_n;

  fft_index_counter #(
    .FFT_N(FFT_N)
  ) u_index (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (accept_start),
    .advance          (issue),
    .j                (cnt_j),
    .g                (cnt_g),
    .stage            (cnt_stage),
    .g_last           (g_last),
    .last_of_stage    (stage_last),
    .last_of_transform(xform_last)
  );

  // A slot with a single group fetches on every issue, so two fetches would
  // land back to back unless a bubble separates them.
  assign need_bubble = (cnt_g == '0) && g_last;

  // bf_top = g * 2^(s+1) + j, bf_bot = bf_top + 2^s
  assign top_n = (({1'b0, cnt_g} << 1) << cnt_stage) | {1'b0, cnt_j};
  assign bot_n = top_n + (AW'(1) << cnt_stage);

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Dwell counter for GAP and DRAIN; restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n || (state_next != state)) wait_cnt <= '0;
    else                                 wait_cnt <= wait_cnt + 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = RUN;
      RUN: begin
        if (out_ready) begin
          if (xform_last)       state_next = DRAIN;
          else if (stage_last)  state_next = GAP;
          else if (need_bubble) state_next = BUBBLE;
        end
      end
      BUBBLE: state_next = RUN;
      GAP:    if (wait_cnt == WW'(STAGE_GAP - 1)) state_next = RUN;
      DRAIN:  if (wait_cnt == WW'(DRAIN_LAT - 1)) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode (registered below)
  always_comb begin
    issue        = (state == RUN) && out_ready;
    accept_start = (state == IDLE) && start;
    busy_d       = (state_next != IDLE);
    done_d       = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      tact_rom <= 1'b0;
      ifft     <= 1'b0;
      stage    <= '0;
      bf_top   <= '0;
      bf_bot   <= '0;
      ta_rom   <= '0;
      evenOdd  <= 1'b0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      tact_rom <= issue;
      if (accept_start) ifft <= ifft_in;
      if (issue) begin
        bf_top  <= top_n;
        bf_bot  <= bot_n;
        ta_rom  <= IW'(twiddle_index(32'(cnt_j), 32'(cnt_stage), FFT_N));
        evenOdd <= (cnt_g != '0);
      end
      // Stage follows each issue, then moves to the new stage during GAP.
      if (accept_start)                 stage <= '0;
      else if (issue || (state == GAP)) stage <= cnt_stage;
    end
  end

`ifdef TWIDDLE_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || accept_start) begin
      rom_fetches  <= '0;
      stall_cycles <= '0;
    end else begin
      if (issue && (cnt_g == '0)) rom_fetches <= rom_fetches + 1'b1;
      if ((state == RUN) && !out_ready && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_twiddle_request_sequencer.sv
// Directed bench for twiddle_request_sequencer with FFT_N = 4.
module tb_twiddle_request_sequencer;
  import fft_pkg::*;

  localparam int FFT_N = 4;
  localparam int SW    = 2;
  localparam int AW    = 4;
  localparam int TW    = 3;
  localparam int EW    = SW + 2 * AW + TW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ifft_in = 1'b0;
  logic out_ready = 1'b0;

  logic          busy;
  logic          done;
  logic [SW-1:0] stage;
  logic [AW-1:0] bf_top;
  logic [AW-1:0] bf_bot;
  logic          tact_rom;
  logic [TW-1:0] ta_rom;
  logic          evenOdd;
  logic          ifft;
  seq_state_e    dbg_state;
`ifdef TWIDDLE_SEQ_STATS_EN
  logic [FFT_N:0] rom_fetches;
  logic [15:0]    stall_cycles;
`endif

  always #5 clk = ~clk;

  twiddle_request_sequencer #(
    .FFT_N(FFT_N),
    .STAGE_GAP(4),
    .DRAIN_LAT(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ifft_in  (ifft_in),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .bf_top   (bf_top),
    .bf_bot   (bf_bot),
    .tact_rom (tact_rom),
    .ta_rom   (ta_rom),
    .evenOdd  (evenOdd),
    .ifft     (ifft),
    .dbg_state(dbg_state)
`ifdef TWIDDLE_SEQ_STATS_EN
    ,
    .rom_fetches (rom_fetches),
    .stall_cycles(stall_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [11:0]   s1_tab[8];   // hand-computed stage 1: {top, bot, ta, evenOdd}
  int  s1_idx;
  int  cyc = 0;
  int  n_issue;
  int  n_done;
  int  last_issue_cyc;
  bit  prev_eo0;
  bit  exp_ifft;
  bit  chk_gap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference issue order: stage, then twiddle slot, then group.
  task automatic load_model();
    exp_q.delete();
    for (int s = 0; s < FFT_N; s++) begin
      for (int j = 0; j < (1 << s); j++) begin
        for (int g = 0; g < (1 << (FFT_N - 1 - s)); g++) begin
          int top;
          int bot;
          int ta;
          top = g * (2 << s) + j;
          bot = top + (1 << s);
          ta  = (j << (FFT_N - 1 - s)) & ((1 << (FFT_N - 1)) - 1);
          exp_q.push_back({SW'(s), AW'(top), AW'(bot), TW'(ta), (g != 0)});
        end
      end
    end
  endtask

  // ---------------- driver / monitor ----------------
  task automatic step();
    logic [EW-1:0] obs;
    @(posedge clk);
    #1;
    cyc++;
    if (tact_rom) begin
      obs = {stage, bf_top, bf_bot, ta_rom, evenOdd};
      if (exp_q.size() == 0) check("extra_issue", 32'd1, 32'd0);
      else                   check("issue", 32'(obs), 32'(exp_q.pop_front()));
      if (!evenOdd) check("rom_occupancy", 32'(prev_eo0), 32'd0);
      if (chk_gap && stage == 2'd3 && bf_top != 4'd0)
        check("bubble_gap", cyc - last_issue_cyc, 32'd2);
      if (stage == 2'd1 && s1_idx < 8) begin
        check("stage1_table", {20'd0, bf_top, bf_bot, ta_rom, evenOdd}, {20'd0, s1_tab[s1_idx]});
        s1_idx++;
      end
      check("ifft", 32'(ifft), 32'(exp_ifft));
      last_issue_cyc = cyc;
      n_issue++;
    end
    prev_eo0 = tact_rom && !evenOdd;
    if (done) n_done++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    32'(busy),     32'd0);
    check({tag, "_done"},    32'(done),     32'd0);
    check({tag, "_tact"},    32'(tact_rom), 32'd0);
    check({tag, "_stage"},   32'(stage),    32'd0);
    check({tag, "_bf_top"},  32'(bf_top),   32'd0);
    check({tag, "_bf_bot"},  32'(bf_bot),   32'd0);
    check({tag, "_ta_rom"},  32'(ta_rom),   32'd0);
    check({tag, "_evenOdd"}, 32'(evenOdd),  32'd0);
    check({tag, "_ifft"},    32'(ifft),     32'd0);
  endtask

  task automatic run_transform(input bit rand_ready, input bit ifft_v, input bit abort);
    bit finished;
    bit aborted;
    finished = 1'b0;
    aborted  = 1'b0;
    load_model();
    n_issue  = 0;
    n_done   = 0;
    prev_eo0 = 1'b0;
    s1_idx   = 0;
    exp_ifft = ifft_v;
    chk_gap  = !rand_ready;
    ifft_in   = ifft_v;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int c = 0; c < 600 && !finished && !aborted; c++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rand_ready) begin
        if (c % 7 == 3) ifft_in = ~ifft_in;
        start = (c == 12);   // start while busy must be ignored
      end
      step();
      start = 1'b0;
      if (abort && tact_rom && stage == 2'd2) begin
        rst_n = 1'b0;
        step();
        check_idle("abort_reset");
        rst_n  = 1'b1;
        n_done = 0;
        repeat (20) step();
        check("no_done_after_abort", n_done, 32'd0);
        aborted = 1'b1;
      end
      if (done) finished = 1'b1;
    end
    start = 1'b0;
    if (!abort) begin
      check("timeout", 32'(finished), 32'd1);
      check("issue_count", n_issue, 32'd32);
      check("exp_q_empty", exp_q.size(), 32'd0);
      check("drain_latency", cyc - last_issue_cyc, 32'd3);
      check("busy_at_done", 32'(busy), 32'd1);
      // start coinciding with done is not accepted
      start = 1'b1;
      step();
      start = 1'b0;
      check("busy_after_done", 32'(busy), 32'd0);
      check("done_one_cycle", 32'(done), 32'd0);
      step();
      check("start_at_done_ignored", 32'(busy), 32'd0);
      check("done_pulses", n_done, 32'd1);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    s1_tab[0] = {4'd0,  4'd2,  3'd0, 1'b0};
    s1_tab[1] = {4'd4,  4'd6,  3'd0, 1'b1};
    s1_tab[2] = {4'd8,  4'd10, 3'd0, 1'b1};
    s1_tab[3] = {4'd12, 4'd14, 3'd0, 1'b1};
    s1_tab[4] = {4'd1,  4'd3,  3'd4, 1'b0};
    s1_tab[5] = {4'd5,  4'd7,  3'd4, 1'b1};
    s1_tab[6] = {4'd9,  4'd11, 3'd4, 1'b1};
    s1_tab[7] = {4'd13, 4'd15, 3'd4, 1'b1};
    chk_gap = 1'b0;
    s1_idx  = 8;

    rst_n = 1'b0;
    repeat (2) step();
    check_idle("reset");
    rst_n = 1'b1;
    step();
    check("idle_no_busy", 32'(busy), 32'd0);

    run_transform(1'b0, 1'b0, 1'b0);   // full-rate forward transform
    run_transform(1'b1, 1'b1, 1'b0);   // random ready, IFFT, input toggling
    run_transform(1'b0, 1'b1, 1'b1);   // reset during stage 2
    run_transform(1'b0, 1'b0, 1'b0);   // clean restart after abort

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
